// File: rtl/rv_alu.sv
// RV32I integer ALU with a one-cycle registered result and valid strobe.
// Optional build macro RV_ALU_FLAGS_EN adds registered zero/carry/overflow flags.

package alu_fns_pkg;

  typedef enum logic [2:0] {
    FnAddSub = 3'b000,
    FnSll    = 3'b001,
    FnSlt    = 3'b010,
    FnSltu   = 3'b011,
    FnXor    = 3'b100,
    FnSrlSra = 3'b101,
    FnOr     = 3'b110,
    FnAnd    = 3'b111
  } alu_fn_t;

  typedef logic [6:0] funct7_t;

  localparam funct7_t F7AddSrl = 7'b0000000;
  localparam funct7_t F7SubSra = 7'b0100000;

endpackage

module rv_alu
  import alu_fns_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  alu_fn_t          fn,
  input  funct7_t          funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef RV_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic             w_alt;
  logic [ShW-1:0]   w_shamt;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_addsub;
  logic             w_lt_s;
  logic             w_lt_u;
  logic [WIDTH-1:0] w_result;
  logic             w_unused_funct7;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;

  assign w_alt   = funct7[5];
  assign w_shamt = b[ShW-1:0];

  // Only bit 5 of funct7 selects a variant; the rest is architecturally ignored.
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Subtract as a + ~b + 1 so the top bit of the sum is carry / not-borrow.
  assign w_sub    = w_alt;
  assign w_b_op   = w_sub ? ~b : b;
  assign w_addsub = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};

  assign w_lt_s = $signed(a) < $signed(b);
  assign w_lt_u = a < b;

  always_comb begin
    w_result = '0;
    case (fn)
      FnAddSub: w_result = w_addsub[WIDTH-1:0];
      FnSll:    w_result = a << w_shamt;
      FnSlt:    w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      FnSltu:   w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      FnXor:    w_result = a ^ b;
      FnSrlSra: w_result = w_alt ? $unsigned($signed(a) >>> w_shamt) : (a >> w_shamt);
      FnOr:     w_result = a | b;
      FnAnd:    w_result = a & b;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_result;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

`ifdef RV_ALU_FLAGS_EN
  logic w_is_addsub;
  logic w_zero;
  logic w_carry;
  logic w_ovf;
  logic r_zero;
  logic r_carry;
  logic r_ovf;

  assign w_is_addsub = (fn == FnAddSub);
  assign w_zero      = (w_result == '0);
  assign w_carry     = w_is_addsub & w_addsub[WIDTH];
  // Signed overflow: operands (after inversion for subtract) agree in sign, result does not.
  assign w_ovf       = w_is_addsub & (a[WIDTH-1] == w_b_op[WIDTH-1])
                                   & (w_addsub[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (in_valid) begin
      r_zero  <= w_zero;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed edge cases, handshake/reset, randomized vs model.
// Flag outputs are checked when RV_ALU_FLAGS_EN is defined.

module tb_rv_alu;
  import alu_fns_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned NRandom = 20000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  alu_fn_t       fn;
  funct7_t       funct7;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  out;
  logic          out_valid;
`ifdef RV_ALU_FLAGS_EN
  logic          zero;
  logic          carry;
  logic          overflow;
`endif

  int n_checks;
  int n_pass;

  rv_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .fn        (fn),
    .funct7    (funct7),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
`ifdef RV_ALU_FLAGS_EN
    ,
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from arithmetic rules, not from the RTL structure.
  function automatic logic [W-1:0] ref_out(input logic [2:0] f, input logic alt,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned       sh;
    longint unsigned   ux;
    longint unsigned   uy;
    logic [W-1:0]      r;
    sh = int'(y % W);
    ux = longint'(x);
    uy = longint'(y);
    case (f)
      3'd0: r = alt ? W'(ux + (64'd1 << W) - uy) : W'(ux + uy);
      3'd1: r = W'(ux * (64'd1 << sh));
      3'd2: r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 1 : 0;
      3'd3: r = (ux < uy) ? 1 : 0;
      3'd4: r = x ^ y;
      3'd5: begin
        r = W'(ux / (64'd1 << sh));
        if (alt && x[W-1]) for (int k = 0; k < sh; k++) r[W-1-k] = 1'b1;
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [2:0] f, input logic alt,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint sr;
    logic   c;
    logic   v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c  = 1'b0;
    v  = 1'b0;
    if (f == 3'd0) begin
      if (alt) begin
        c  = (x >= y);
        sr = sx - sy;
      end else begin
        c  = (longint'(x) + longint'(y)) >= (64'sd1 <<< W);
        sr = sx + sy;
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    return {ref_out(f, alt, x, y) == '0, c, v};
  endfunction

  task automatic apply(input logic [2:0] f, input logic alt,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    fn       = alu_fn_t'(f);
    funct7   = alt ? F7SubSra : F7AddSrl;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    fn       = FnAddSub;
    funct7   = F7AddSrl;
    a        = '0;
    b        = '0;
    #2;
    n_checks++;
    if (out !== '0 || out_valid !== 1'b0)
      $display("FAIL reset_async: out=%h valid=%b, want 0/0", out, out_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out !== '0 || out_valid !== 1'b0)
      $display("FAIL reset_held: out=%h valid=%b, want 0/0", out, out_valid);
    else n_pass++;
`ifdef RV_ALU_FLAGS_EN
    n_checks++;
    if ({zero, carry, overflow} !== 3'b000)
      $display("FAIL reset_flags: flags=%b, want 000", {zero, carry, overflow});
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith;
    logic [2:0]   f[5]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic         s[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] x[5]  = '{32'hFFFF_FFFF, -32'sd5, 32'd5, 32'd5, -32'sd5};
    logic [W-1:0] y[5]  = '{32'd1, 32'd6, -32'sd6, -32'sd6, 32'd6};
    logic [W-1:0] e[5]  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                            32'h0000_000B, 32'hFFFF_FFF5};
    for (int i = 0; i < 5; i++) begin
      apply(f[i], s[i], x[i], y[i]);
      n_checks++;
      if (out !== e[i] || out_valid !== 1'b1)
        $display("FAIL arith_%0d: out=%h valid=%b, want %h/1", i, out, out_valid, e[i]);
      else n_pass++;
    end
    apply(3'd1, 1'b1, 32'd3, 32'd1); // funct7 ignored outside ADD_SUB/SRL_SRA
    n_checks++;
    if (out !== 32'd6) $display("FAIL sll_ignores_f7: out=%h, want 00000006", out);
    else n_pass++;
  endtask

  task automatic test_shift;
    logic [2:0]   f[3] = '{3'd5, 3'd5, 3'd1};
    logic         s[3] = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] x[3] = '{32'h8000_0000, 32'h8000_0000, 32'd1};
    logic [W-1:0] y[3] = '{32'd4, 32'd4, 32'd33};
    logic [W-1:0] e[3] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0002};
    for (int i = 0; i < 3; i++) begin
      apply(f[i], s[i], x[i], y[i]);
      n_checks++;
      if (out !== e[i]) $display("FAIL shift_%0d: out=%h, want %h", i, out, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_compare;
    logic [2:0]   f[4] = '{3'd2, 3'd3, 3'd2, 3'd3};
    logic [W-1:0] x[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic [W-1:0] y[4] = '{32'd1, 32'd1, 32'd7, 32'd7};
    logic [W-1:0] e[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      apply(f[i], 1'b0, x[i], y[i]);
      n_checks++;
      if (out !== e[i]) $display("FAIL compare_%0d: out=%h, want %h", i, out, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_logic;
    logic [2:0]   f[3] = '{3'd7, 3'd6, 3'd4};
    logic [W-1:0] e[3] = '{32'h00F0_0000, 32'hFFF0_FFFF, 32'hFF00_FFFF};
    for (int i = 0; i < 3; i++) begin
      apply(f[i], 1'b0, 32'hF0F0_A5A5, 32'h0FF0_5A5A);
      n_checks++;
      if (out !== e[i]) $display("FAIL logic_%0d: out=%h, want %h", i, out, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) begin
      apply(3'd0, 1'b0, 32'd100 * (i + 1), 32'd1);
      n_checks++;
      if (out !== 32'd100 * (i + 1) + 1 || out_valid !== 1'b1)
        $display("FAIL b2b_%0d: out=%h valid=%b, want %h/1", i, out, out_valid,
                 32'd100 * (i + 1) + 1);
      else n_pass++;
    end
    held     = 32'd401;
    in_valid = 1'b0;
    a        = 32'h1234_5678;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out !== held)
      $display("FAIL gap: out=%h valid=%b, want %h/0", out, out_valid, held);
    else n_pass++;
    apply(3'd4, 1'b0, 32'hFF, 32'h0F);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 32'hF0)
      $display("FAIL after_gap: out=%h valid=%b, want 000000f0/1", out, out_valid);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    apply(3'd6, 1'b0, 32'hA000_0000, 32'h5);
    in_valid = 1'b1;
    a        = 32'h1111_1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== '0 || out_valid !== 1'b0)
      $display("FAIL mid_reset: out=%h valid=%b, want 0/0", out, out_valid);
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out !== '0 || out_valid !== 1'b0)
      $display("FAIL reset_drop: out=%h valid=%b, want 0/0", out, out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    fn       = FnAddSub;
    funct7   = F7SubSra;
    a        = 32'h8000_0000;
    b        = 32'd1;
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out !== 32'h7FFF_FFFF || out_valid !== 1'b1)
      $display("FAIL reset_first_op: out=%h valid=%b, want 7fffffff/1", out, out_valid);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [2:0]   f;
    logic [6:0]   f7;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           errs;
    errs = 0;
    for (int i = 0; i < NRandom; i++) begin
      f  = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      x  = $urandom;
      y  = $urandom;
      if (i % 8 == 0) y = x;
      if (i % 16 == 1) x = 32'h8000_0000;
      in_valid = 1'b1;
      fn       = alu_fn_t'(f);
      funct7   = f7;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
      n_checks++;
      if (out !== ref_out(f, f7[5], x, y) || out_valid !== 1'b1) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_%0d fn=%0d f7=%h a=%h b=%h: out=%h valid=%b, want %h/1", i, f,
                   f7, x, y, out, out_valid, ref_out(f, f7[5], x, y));
      end else n_pass++;
`ifdef RV_ALU_FLAGS_EN
      n_checks++;
      if ({zero, carry, overflow} !== ref_flags(f, f7[5], x, y)) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_flags_%0d fn=%0d a=%h b=%h: zco=%b, want %b", i, f, x, y,
                   {zero, carry, overflow}, ref_flags(f, f7[5], x, y));
      end else n_pass++;
`endif
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_logic();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
